// File: rtl/com_proc.sv
// com_proc: command processor for the follower robot.
// Consumes go/stop commands and station IDs, tracks in_transit, gates motion
// with Ok2Move and drives a piezo tone while the robot is in transit but blocked.
module com_proc #(
  parameter int BUZZ_HALF = 12500
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_rdy,
  input  logic [7:0] cmd,
  input  logic       ID_vld,
  input  logic [7:0] ID,
  input  logic       Ok2Move,
  output logic       clr_cmd_rdy,
  output logic       clr_ID_vld,
  output logic       go,
  output logic       in_transit,
  output logic       buzz,
  output logic       buzz_n
);

  localparam int CW = (BUZZ_HALF > 1) ? $clog2(BUZZ_HALF) : 1;

  typedef enum logic [1:0] {IDLE, CMD_RDY, ID_VLD} state_t;

  state_t          state_q, state_d;
  logic [5:0]      dest_id_q, dest_id_d;
  logic            in_transit_q, in_transit_d;
  logic [7:0]      id_cap_q, id_cap_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            buzz_q, buzz_d;

  // strobes produced by the FSM
  logic set_in_transit, clr_in_transit, load_dest, cap_id;
  logic clr_cmd_rdy_s, clr_id_vld_s;
  logic piezo_en;

  // Command/ID FSM: next state and one-cycle strobes.
  always_comb begin
    state_d        = state_q;
    set_in_transit = 1'b0;
    clr_in_transit = 1'b0;
    load_dest      = 1'b0;
    cap_id         = 1'b0;
    clr_cmd_rdy_s  = 1'b0;
    clr_id_vld_s   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (cmd_rdy) begin
          clr_cmd_rdy_s = 1'b1;
          if (cmd[7:6] == 2'b01) begin
            load_dest      = 1'b1;
            set_in_transit = 1'b1;
            state_d        = CMD_RDY;
          end
        end else if (ID_vld) begin
          // no destination yet, so any ID is stale
          clr_id_vld_s = 1'b1;
        end
      end
      CMD_RDY: begin
        if (cmd_rdy) begin
          clr_cmd_rdy_s = 1'b1;
          if (cmd[7:6] == 2'b01) begin
            load_dest = 1'b1;
          end else if (cmd[7:6] == 2'b00) begin
            clr_in_transit = 1'b1;
            state_d        = IDLE;
          end
        end else if (ID_vld) begin
          cap_id       = 1'b1;
          clr_id_vld_s = 1'b1;
          state_d      = ID_VLD;
        end
      end
      ID_VLD: begin
        if ((id_cap_q[7:6] == 2'b00) && (id_cap_q[5:0] == dest_id_q)) begin
          clr_in_transit = 1'b1;
          state_d        = IDLE;
        end else begin
          state_d = CMD_RDY;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values: destination, capture register, transit flag (set wins).
  always_comb begin
    dest_id_d    = load_dest ? cmd[5:0] : dest_id_q;
    id_cap_d     = cap_id ? ID : id_cap_q;
    in_transit_d = in_transit_q;
    if (clr_in_transit) in_transit_d = 1'b0;
    if (set_in_transit) in_transit_d = 1'b1;
  end

  // Buzzer: half-period counter toggles buzz on wrap; idle forces both to 0.
  always_comb begin
    piezo_en = in_transit_q & ~Ok2Move;
    cnt_d    = '0;
    buzz_d   = 1'b0;
    if (piezo_en) begin
      if (cnt_q == CW'(BUZZ_HALF - 1)) begin
        cnt_d  = '0;
        buzz_d = ~buzz_q;
      end else begin
        cnt_d  = cnt_q + 1'b1;
        buzz_d = buzz_q;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      dest_id_q    <= '0;
      in_transit_q <= 1'b0;
      id_cap_q     <= '0;
      cnt_q        <= '0;
      buzz_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      dest_id_q    <= dest_id_d;
      in_transit_q <= in_transit_d;
      id_cap_q     <= id_cap_d;
      cnt_q        <= cnt_d;
      buzz_q       <= buzz_d;
    end
  end

  // Strobes are suppressed while reset is held so nothing is consumed then.
  assign clr_cmd_rdy = clr_cmd_rdy_s & rst_n;
  assign clr_ID_vld  = clr_id_vld_s & rst_n;
  assign in_transit  = in_transit_q;
  assign go          = in_transit_q & Ok2Move;
  assign buzz        = buzz_q;
  assign buzz_n      = ~buzz_q;

endmodule

// File: tb/tb_com_proc.sv
// Directed bench for com_proc; BUZZ_HALF shrunk to 4 to keep the tone test short.
module tb_com_proc;
  localparam int BH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_rdy = 1'b0;
  logic [7:0] cmd = 8'h00;
  logic       ID_vld = 1'b0;
  logic [7:0] ID = 8'h00;
  logic       Ok2Move = 1'b0;
  logic       clr_cmd_rdy, clr_ID_vld, go, in_transit, buzz, buzz_n;

  int total = 0;
  int bad = 0;

  com_proc #(.BUZZ_HALF(BH)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_rdy(cmd_rdy), .cmd(cmd), .ID_vld(ID_vld), .ID(ID),
    .Ok2Move(Ok2Move), .clr_cmd_rdy(clr_cmd_rdy), .clr_ID_vld(clr_ID_vld), .go(go),
    .in_transit(in_transit), .buzz(buzz), .buzz_n(buzz_n)
  );

  always #10 clk = ~clk;

  // inputs change on the falling edge; outputs read 1 time unit later
  task automatic nstep();
    @(negedge clk); #1;
  endtask

  // drive a one-cycle command (upstream drops cmd_rdy once clr arrives)
  task automatic send_cmd(input logic [7:0] c);
    @(negedge clk); cmd_rdy = 1'b1; cmd = c;
    @(negedge clk); cmd_rdy = 1'b0; #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cmd_rdy = 1'b1; cmd = 8'h75; ID_vld = 1'b1; ID = 8'h00; Ok2Move = 1'b1;
    nstep(); nstep();
    total++; if (clr_cmd_rdy !== 1'b0) begin bad++; $display("FAIL reset_clr_cmd got=%b want=0", clr_cmd_rdy); end
    total++; if (clr_ID_vld !== 1'b0) begin bad++; $display("FAIL reset_clr_id got=%b want=0", clr_ID_vld); end
    total++; if (in_transit !== 1'b0 || go !== 1'b0) begin bad++; $display("FAIL reset_transit got it=%b go=%b want 0 0", in_transit, go); end
    total++; if (buzz !== 1'b0 || buzz_n !== 1'b1) begin bad++; $display("FAIL reset_buzz got=%b/%b want 0/1", buzz, buzz_n); end
    cmd_rdy = 1'b0; ID_vld = 1'b0;
    rst_n = 1'b1;
    nstep();
  endtask

  task automatic test_ignored_cmd();
    @(negedge clk); cmd_rdy = 1'b1; cmd = 8'hBF; #1;
    total++; if (clr_cmd_rdy !== 1'b1) begin bad++; $display("FAIL ign_clr got=%b want=1", clr_cmd_rdy); end
    @(negedge clk); cmd_rdy = 1'b0; #1;
    total++; if (clr_cmd_rdy !== 1'b0) begin bad++; $display("FAIL ign_clr_width got=%b want=0", clr_cmd_rdy); end
    total++; if (in_transit !== 1'b0 || go !== 1'b0) begin bad++; $display("FAIL ign_transit got it=%b go=%b want 0 0", in_transit, go); end
    // stale ID in IDLE is consumed without starting a compare
    @(negedge clk); ID_vld = 1'b1; ID = 8'h00; #1;
    total++; if (clr_ID_vld !== 1'b1) begin bad++; $display("FAIL idle_stale_id got=%b want=1", clr_ID_vld); end
    @(negedge clk); ID_vld = 1'b0; #1;
    total++; if (clr_ID_vld !== 1'b0 || in_transit !== 1'b0) begin bad++; $display("FAIL idle_stale_after got clr=%b it=%b want 0 0", clr_ID_vld, in_transit); end
  endtask

  task automatic test_go();
    Ok2Move = 1'b1;
    @(negedge clk); cmd_rdy = 1'b1; cmd = 8'h75; #1;
    total++; if (clr_cmd_rdy !== 1'b1 || in_transit !== 1'b0) begin bad++; $display("FAIL go_strobe got clr=%b it=%b want 1 0", clr_cmd_rdy, in_transit); end
    @(negedge clk); cmd_rdy = 1'b0; #1;
    total++; if (in_transit !== 1'b1 || go !== 1'b1) begin bad++; $display("FAIL go_transit got it=%b go=%b want 1 1", in_transit, go); end
    total++; if (clr_cmd_rdy !== 1'b0 || buzz !== 1'b0) begin bad++; $display("FAIL go_quiet got clr=%b buzz=%b want 0 0", clr_cmd_rdy, buzz); end
  endtask

  // ID compare against dest 0x35; returns in_transit after the compare cycle
  task automatic id_probe(input logic [7:0] id_val, input logic exp_it, input string nm);
    @(negedge clk); ID_vld = 1'b1; ID = id_val; #1;
    total++; if (clr_ID_vld !== 1'b1) begin bad++; $display("FAIL %s_clr got=%b want=1", nm, clr_ID_vld); end
    @(negedge clk); ID_vld = 1'b0; #1;
    total++; if (clr_ID_vld !== 1'b0 || in_transit !== 1'b1) begin bad++; $display("FAIL %s_cmp got clr=%b it=%b want 0 1", nm, clr_ID_vld, in_transit); end
    nstep();
    total++; if (in_transit !== exp_it) begin bad++; $display("FAIL %s_result got=%b want=%b", nm, in_transit, exp_it); end
  endtask

  task automatic test_ids();
    id_probe(8'h03, 1'b1, "id_mismatch");
    id_probe(8'h75, 1'b1, "id_badprefix");
    id_probe(8'h35, 1'b0, "id_match");
    total++; if (go !== 1'b0) begin bad++; $display("FAIL id_match_go got=%b want=0", go); end
  endtask

  task automatic test_stop();
    send_cmd(8'h75);
    total++; if (in_transit !== 1'b1) begin bad++; $display("FAIL stop_pre got=%b want=1", in_transit); end
    // unrecognised command while travelling is consumed, transit kept
    @(negedge clk); cmd_rdy = 1'b1; cmd = 8'hBF; #1;
    total++; if (clr_cmd_rdy !== 1'b1) begin bad++; $display("FAIL other_clr got=%b want=1", clr_cmd_rdy); end
    @(negedge clk); cmd_rdy = 1'b0; #1;
    total++; if (in_transit !== 1'b1) begin bad++; $display("FAIL other_keep got=%b want=1", in_transit); end
    @(negedge clk); cmd_rdy = 1'b1; cmd = 8'h0D; #1;
    total++; if (clr_cmd_rdy !== 1'b1) begin bad++; $display("FAIL stop_clr got=%b want=1", clr_cmd_rdy); end
    @(negedge clk); cmd_rdy = 1'b0; #1;
    total++; if (in_transit !== 1'b0 || go !== 1'b0 || clr_cmd_rdy !== 1'b0) begin bad++; $display("FAIL stop_result got it=%b go=%b clr=%b want 0 0 0", in_transit, go, clr_cmd_rdy); end
  endtask

  task automatic test_back_to_back();
    send_cmd(8'h75);
    @(negedge clk); cmd_rdy = 1'b1; cmd = 8'h4C; ID_vld = 1'b1; ID = 8'h0C; #1;
    total++; if (clr_cmd_rdy !== 1'b1 || clr_ID_vld !== 1'b0) begin bad++; $display("FAIL b2b_prio got cc=%b ci=%b want 1 0", clr_cmd_rdy, clr_ID_vld); end
    @(negedge clk); cmd_rdy = 1'b0; #1;
    total++; if (clr_ID_vld !== 1'b1 || clr_cmd_rdy !== 1'b0) begin bad++; $display("FAIL b2b_id_later got ci=%b cc=%b want 1 0", clr_ID_vld, clr_cmd_rdy); end
    @(negedge clk); ID_vld = 1'b0; #1;
    nstep();
    total++; if (in_transit !== 1'b0) begin bad++; $display("FAIL b2b_retarget got it=%b want=0", in_transit); end
  endtask

  task automatic test_buzz();
    logic exp_b;
    send_cmd(8'h75);
    @(negedge clk); Ok2Move = 1'b0; #1;
    total++; if (go !== 1'b0 || buzz !== 1'b0) begin bad++; $display("FAIL buzz_start got go=%b buzz=%b want 0 0", go, buzz); end
    for (int n = 1; n <= 3 * BH; n++) begin
      nstep();
      exp_b = ((n / BH) % 2) == 1;
      total++; if (buzz !== exp_b || buzz_n !== ~exp_b) begin bad++; $display("FAIL buzz_tone n=%0d got=%b/%b want=%b/%b", n, buzz, buzz_n, exp_b, ~exp_b); end
    end
    @(negedge clk); Ok2Move = 1'b1; #1;
    total++; if (go !== 1'b1) begin bad++; $display("FAIL buzz_clear_go got=%b want=1", go); end
    nstep();
    total++; if (buzz !== 1'b0 || buzz_n !== 1'b1) begin bad++; $display("FAIL buzz_off got=%b/%b want 0/1", buzz, buzz_n); end
    // a new blocked stretch restarts the half-period from zero
    @(negedge clk); Ok2Move = 1'b0; #1;
    for (int n = 1; n <= BH; n++) nstep();
    total++; if (buzz !== 1'b1) begin bad++; $display("FAIL buzz_restart got=%b want=1", buzz); end
  endtask

  task automatic test_reset_mid_transit();
    total++; if (in_transit !== 1'b1) begin bad++; $display("FAIL rst_mid_pre got=%b want=1", in_transit); end
    Ok2Move = 1'b1;
    @(negedge clk); rst_n = 1'b0; #1;
    total++; if (in_transit !== 1'b0 || go !== 1'b0 || buzz !== 1'b0) begin bad++; $display("FAIL rst_mid got it=%b go=%b buzz=%b want 0 0 0", in_transit, go, buzz); end
    @(negedge clk); rst_n = 1'b1; #1;
    // back in IDLE: an ID is just discarded and nothing starts
    @(negedge clk); ID_vld = 1'b1; ID = 8'h00; #1;
    total++; if (clr_ID_vld !== 1'b1) begin bad++; $display("FAIL rst_mid_idle got=%b want=1", clr_ID_vld); end
    @(negedge clk); ID_vld = 1'b0; #1;
    total++; if (in_transit !== 1'b0) begin bad++; $display("FAIL rst_mid_after got=%b want=0", in_transit); end
  endtask

  initial begin
    test_reset();
    test_ignored_cmd();
    test_go();
    test_ids();
    test_stop();
    test_back_to_back();
    test_buzz();
    test_reset_mid_transit();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
